// File: rtl/gpa_fhdo_pkg.sv
// Shared types, field positions and DAC word builder for the GPA-FHDO sequencer.
// The ADC readback option is enabled by defining GPA_FHDO_ADC_READBACK_EN.
package gpa_fhdo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ADC_ISSUE = 3'd4
    } state_e;

    localparam logic [3:0] DAC_ADDR_BASE = 4'b1000;
    localparam int         BCAST_BIT     = 24;
    localparam int         ADC_SEL_BIT   = 30;

    // {4'h0, DAC-n register address, value}; broadcast and ADC select stay clear
    function automatic logic [31:0] dac_word(input logic [1:0] ch, input logic [15:0] val);
        logic [31:0] w;
        w = {8'h00, 4'h0, DAC_ADDR_BASE | {2'b00, ch}, val};
        w[BCAST_BIT]   = 1'b0;
        w[ADC_SEL_BIT] = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/gpa_fhdo_rr_pick.sv
// Combinational 4-way round-robin pick: lowest pending channel at or after rr_i, wrapping 3->0.
module gpa_fhdo_rr_pick
    import gpa_fhdo_pkg::*;
(
    input  logic [3:0] pending_i,
    input  logic [1:0] rr_i,
    output logic [1:0] ch_o,
    output logic       valid_o
);

    // rot[k] is the pending bit of the channel k steps after the pointer
    logic [3:0] rot;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot[gi] = pending_i[rr_i + 2'(gi)];
        end
    endgenerate

    always_comb begin
        ch_o    = rr_i;
        valid_o = |pending_i;
        for (int k = 3; k >= 0; k--) begin
            if (rot[k]) begin
                ch_o = rr_i + 2'(k);
            end
        end
    end

endmodule

// File: rtl/gpa_fhdo_sequencer.sv
// Latches 4-channel gradient updates and drains them one DAC word at a time to the SPI serialiser.
// Define GPA_FHDO_ADC_READBACK_EN to add an ADC readback word after each drained batch.
module gpa_fhdo_sequencer
    import gpa_fhdo_pkg::*;
#(
    parameter int          BUSY_TIMEOUT = 16,
    parameter logic [23:0] ADC_CMD      = 24'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd_i,
    input  logic [3:0]  upd_mask_i,
    input  logic [63:0] upd_data_i,
    output logic [31:0] iface_data_o,
    output logic        iface_valid_o,
    input  logic        iface_busy_i,
    output logic [3:0]  pending_o,
    output logic        busy_o,
    output logic [7:0]  overrun_o,
    output logic        timeout_o
`ifdef GPA_FHDO_ADC_READBACK_EN
    ,
    output logic        adc_done_o
`endif
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [3:0]       pending_q, pending_d;
    logic [15:0]      value_q [4];
    logic [1:0]       rr_q, rr_d;
    logic [1:0]       sel_q, sel_d;
    logic [31:0]      data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       overrun_q, overrun_d;
    logic             timeout_q, timeout_d;

    logic [1:0]       pick_ch;
    logic             pick_valid;
    logic [3:0]       issue_mask;
    logic [3:0]       ovr_lanes;
    logic [2:0]       ovr_inc;
    logic [8:0]       ovr_sum;
    logic [31:0]      word_out;
    logic             valid_out;

`ifdef GPA_FHDO_ADC_READBACK_EN
    logic             dac_sent_q, dac_sent_d;
    logic             adc_xfer_q, adc_xfer_d;
    logic             adc_done_q, adc_done_d;
    logic [31:0]      adc_word;

    always_comb begin
        adc_word              = {8'h00, ADC_CMD};
        adc_word[ADC_SEL_BIT] = 1'b1;
    end
`endif

    gpa_fhdo_rr_pick u_pick (
        .pending_i (pending_q),
        .rr_i      (rr_q),
        .ch_o      (pick_ch),
        .valid_o   (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        valid_out  = 1'b0;
        word_out   = data_q;
        issue_mask = 4'b0000;
`ifdef GPA_FHDO_ADC_READBACK_EN
        dac_sent_d = dac_sent_q;
        adc_xfer_d = adc_xfer_q;
        adc_done_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_ch;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Word is taken from the stored value before any same-cycle update lands
                valid_out         = 1'b1;
                word_out          = dac_word(sel_q, value_q[sel_q]);
                issue_mask[sel_q] = 1'b1;
                rr_d              = sel_q + 2'd1;
                cnt_d             = '0;
                state_d           = ST_WAIT_BUSY;
`ifdef GPA_FHDO_ADC_READBACK_EN
                dac_sent_d        = 1'b1;
`endif
            end
            ST_WAIT_BUSY: begin
                if (iface_busy_i) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    timeout_d  = 1'b1;
                    state_d    = ST_IDLE;
`ifdef GPA_FHDO_ADC_READBACK_EN
                    adc_xfer_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!iface_busy_i) begin
                    state_d = ST_IDLE;
`ifdef GPA_FHDO_ADC_READBACK_EN
                    if (adc_xfer_q) begin
                        adc_xfer_d = 1'b0;
                        adc_done_d = 1'b1;
                    end else if (pending_q == 4'b0000 && dac_sent_q) begin
                        state_d = ST_ADC_ISSUE;
                    end
`endif
                end
            end
`ifdef GPA_FHDO_ADC_READBACK_EN
            ST_ADC_ISSUE: begin
                valid_out  = 1'b1;
                word_out   = adc_word;
                dac_sent_d = 1'b0;
                adc_xfer_d = 1'b1;
                cnt_d      = '0;
                state_d    = ST_WAIT_BUSY;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A lane re-written while it is being issued simply re-pends; it is not an overrun
    always_comb begin
        pending_d = pending_q & ~issue_mask;
        ovr_lanes = 4'b0000;
        if (upd_i) begin
            pending_d = pending_d | upd_mask_i;
            ovr_lanes = upd_mask_i & pending_q & ~issue_mask;
        end
        ovr_inc   = {2'b00, ovr_lanes[0]} + {2'b00, ovr_lanes[1]}
                  + {2'b00, ovr_lanes[2]} + {2'b00, ovr_lanes[3]};
        ovr_sum   = {1'b0, overrun_q} + {6'b000000, ovr_inc};
        overrun_d = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
        data_d    = word_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= 4'b0000;
            rr_q      <= 2'd0;
            sel_q     <= 2'd0;
            data_q    <= 32'd0;
            cnt_q     <= '0;
            overrun_q <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                value_q[n] <= 16'd0;
            end
        end else if (upd_i) begin
            for (int n = 0; n < 4; n++) begin
                if (upd_mask_i[n]) begin
                    value_q[n] <= upd_data_i[16*n +: 16];
                end
            end
        end
    end

`ifdef GPA_FHDO_ADC_READBACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_sent_q <= 1'b0;
            adc_xfer_q <= 1'b0;
            adc_done_q <= 1'b0;
        end else begin
            dac_sent_q <= dac_sent_d;
            adc_xfer_q <= adc_xfer_d;
            adc_done_q <= adc_done_d;
        end
    end

    assign adc_done_o = adc_done_q;
`endif

    assign iface_data_o  = word_out;
    assign iface_valid_o = valid_out;
    assign pending_o     = pending_q;
    assign busy_o        = (state_q != ST_IDLE) || (pending_q != 4'b0000);
    assign overrun_o     = overrun_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_gpa_fhdo_sequencer.sv
// Directed bench for gpa_fhdo_sequencer with a behavioural serialiser busy model.
// Define GPA_FHDO_ADC_READBACK_EN to also exercise the ADC readback word.
module tb_gpa_fhdo_sequencer;

    localparam logic [23:0] TB_ADC_CMD = 24'h123456;
    localparam int          BUSY_LEN   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        upd_i;
    logic [3:0]  upd_mask_i;
    logic [63:0] upd_data_i;
    logic [31:0] iface_data_o;
    logic        iface_valid_o;
    logic        iface_busy_i;
    logic [3:0]  pending_o;
    logic        busy_o;
    logic [7:0]  overrun_o;
    logic        timeout_o;
`ifdef GPA_FHDO_ADC_READBACK_EN
    logic        adc_done_o;
`endif

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] dac_q[$];
    logic [31:0] adc_q[$];
    int          overlap_cnt  = 0;
    int          adc_done_cnt = 0;
    int          bm_mode      = 0;   // 0: normal busy pulse, 1: never busy, 2: busy stuck high
    int          bm_cnt       = 0;

    gpa_fhdo_sequencer #(
        .BUSY_TIMEOUT (16),
        .ADC_CMD      (TB_ADC_CMD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .upd_i         (upd_i),
        .upd_mask_i    (upd_mask_i),
        .upd_data_i    (upd_data_i),
        .iface_data_o  (iface_data_o),
        .iface_valid_o (iface_valid_o),
        .iface_busy_i  (iface_busy_i),
        .pending_o     (pending_o),
        .busy_o        (busy_o),
        .overrun_o     (overrun_o),
        .timeout_o     (timeout_o)
`ifdef GPA_FHDO_ADC_READBACK_EN
        ,
        .adc_done_o    (adc_done_o)
`endif
    );

    always #5 clk = ~clk;

    // Serialiser model and word monitor, both working on the falling edge
    initial begin
        iface_busy_i = 1'b0;
        forever begin
            @(negedge clk);
            if (iface_valid_o) begin
                $display("[%0t] word %08h", $time, iface_data_o);
                if (iface_busy_i) overlap_cnt++;
                if (iface_data_o[30]) adc_q.push_back(iface_data_o);
                else                  dac_q.push_back(iface_data_o);
                if (bm_mode != 1) begin
                    iface_busy_i = 1'b1;
                    bm_cnt       = BUSY_LEN;
                end
            end else if (iface_busy_i && bm_mode != 2) begin
                if (bm_cnt > 1) bm_cnt--;
                else            iface_busy_i = 1'b0;
            end
`ifdef GPA_FHDO_ADC_READBACK_EN
            if (adc_done_o) adc_done_cnt++;
`endif
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        upd_i      = 1'b0;
        upd_mask_i = 4'h0;
        upd_data_i = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        dac_q.delete();
        adc_q.delete();
    endtask

    task automatic do_upd(input logic [3:0] mask, input logic [63:0] data);
        @(posedge clk);
        #1;
        upd_i      = 1'b1;
        upd_mask_i = mask;
        upd_data_i = data;
        @(posedge clk);
        #1;
        upd_i      = 1'b0;
        upd_mask_i = 4'h0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (!busy_o) begin
                done = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!done) $display("FAIL %s idle_wait: busy_o still 1 after %0d cycles, required 0", name, budget);
        else n_pass++;
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (iface_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        upd_i = 1'b0; upd_mask_i = 4'h0; upd_data_i = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (iface_data_o !== 32'd0) $display("FAIL reset_data: got %08h need 00000000", iface_data_o); else n_pass++;
        n_checks++; if (iface_valid_o !== 1'b0) $display("FAIL reset_valid: got %b need 0", iface_valid_o); else n_pass++;
        n_checks++; if (pending_o !== 4'h0) $display("FAIL reset_pending: got %h need 0", pending_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b need 0", busy_o); else n_pass++;
        n_checks++; if ({overrun_o, timeout_o} !== 9'd0) $display("FAIL reset_counters: got ovr=%0d to=%b need 0/0", overrun_o, timeout_o); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] exp_hold;
        apply_reset();
        do_upd(4'b0001, 64'h0000_0000_0000_1234);
        wait_idle(200, "single");
`ifdef GPA_FHDO_ADC_READBACK_EN
        exp_hold = 32'h40123456;
`else
        exp_hold = 32'h00081234;
`endif
        n_checks++; if (dac_q.size() != 1) $display("FAIL single_count: got %0d words need 1", dac_q.size()); else n_pass++;
        n_checks++; if (dac_q[0] !== 32'h00081234) $display("FAIL single_word: got %08h need 00081234", dac_q[0]); else n_pass++;
        n_checks++; if (iface_data_o !== exp_hold) $display("FAIL single_hold: got %08h need %08h", iface_data_o, exp_hold); else n_pass++;
        n_checks++; if (pending_o !== 4'h0) $display("FAIL single_pending: got %h need 0", pending_o); else n_pass++;
    endtask

    task automatic test_four_channels();
        logic [31:0] exp [4];
        exp = '{32'h00080001, 32'h00090002, 32'h000A0003, 32'h000B0004};
        apply_reset();
        overlap_cnt = 0;
        do_upd(4'hF, {16'd4, 16'd3, 16'd2, 16'd1});
        wait_idle(300, "four");
        n_checks++; if (dac_q.size() != 4) $display("FAIL four_count: got %0d words need 4", dac_q.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (dac_q[i] !== exp[i]) $display("FAIL four_word%0d: got %08h need %08h", i, dac_q[i], exp[i]); else n_pass++;
        end
        n_checks++; if (overlap_cnt != 0) $display("FAIL four_overlap: got %0d pulses during busy need 0", overlap_cnt); else n_pass++;
    endtask

    task automatic test_rr_wrap();
        apply_reset();
        do_upd(4'b0001, 64'h0000_0000_0000_00AA);
        wait_idle(200, "rr_first");
        dac_q.delete();
        do_upd(4'hF, {16'h0013, 16'h0012, 16'h0011, 16'h0010});
        wait_idle(300, "rr_wrap");
        n_checks++; if (dac_q[0] !== 32'h00090011) $display("FAIL rr_first: got %08h need 00090011", dac_q[0]); else n_pass++;
        n_checks++; if (dac_q[3] !== 32'h00080010) $display("FAIL rr_last: got %08h need 00080010", dac_q[3]); else n_pass++;
    endtask

    task automatic test_overwrite();
        apply_reset();
        do_upd(4'b0001, 64'h0000_0000_0000_1111);
        do_upd(4'b0100, 64'h0000_AAAA_0000_0000);
        do_upd(4'b0100, 64'h0000_BBBB_0000_0000);
        wait_idle(300, "overwrite");
        n_checks++; if (dac_q.size() != 2) $display("FAIL ovw_count: got %0d words need 2", dac_q.size()); else n_pass++;
        n_checks++; if (dac_q[1] !== 32'h000ABBBB) $display("FAIL ovw_word: got %08h need 000ABBBB", dac_q[1]); else n_pass++;
        n_checks++; if (overrun_o !== 8'd1) $display("FAIL ovw_overrun: got %0d need 1", overrun_o); else n_pass++;
    endtask

    task automatic test_issue_collision();
        apply_reset();
        do_upd(4'b0010, 64'h0000_0000_0101_0000);
        do_upd(4'b0010, 64'h0000_0000_0202_0000);
        wait_idle(300, "collision");
        n_checks++; if (dac_q[0] !== 32'h00090101) $display("FAIL coll_old: got %08h need 00090101", dac_q[0]); else n_pass++;
        n_checks++; if (dac_q[1] !== 32'h00090202) $display("FAIL coll_new: got %08h need 00090202", dac_q[1]); else n_pass++;
        n_checks++; if (overrun_o !== 8'd0) $display("FAIL coll_overrun: got %0d need 0", overrun_o); else n_pass++;
    endtask

    task automatic test_overrun_saturate();
        apply_reset();
        bm_mode = 2;
        do_upd(4'b0001, 64'd0);
        repeat (4) @(posedge clk);
        for (int i = 0; i < 64; i++) do_upd(4'hF, {16'h0d04, 16'h0c03, 16'h0b02, 16'h0a01});
        n_checks++; if (overrun_o !== 8'd252) $display("FAIL sat_count: got %0d need 252", overrun_o); else n_pass++;
        do_upd(4'hF, 64'd0);
        n_checks++; if (overrun_o !== 8'd255) $display("FAIL sat_clip: got %0d need 255", overrun_o); else n_pass++;
        do_upd(4'hF, 64'd0);
        n_checks++; if (overrun_o !== 8'd255) $display("FAIL sat_hold: got %0d need 255", overrun_o); else n_pass++;
        bm_mode = 0;
        wait_idle(400, "saturate");
    endtask

    task automatic test_timeout();
        bit seen;
        apply_reset();
        bm_mode = 1;
        do_upd(4'b0011, 64'h0000_0000_0006_0005);
        wait_valid(20, seen);
        n_checks++; if (!seen) $display("FAIL to_first_pulse: got none need pulse"); else n_pass++;
        repeat (16) @(posedge clk);
        #1;
        n_checks++; if (timeout_o !== 1'b0) $display("FAIL to_early: got %b need 0", timeout_o); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (timeout_o !== 1'b1) $display("FAIL to_set: got %b need 1", timeout_o); else n_pass++;
        wait_valid(10, seen);
        n_checks++; if (!seen || iface_data_o !== 32'h00090006) $display("FAIL to_next: seen=%b got %08h need 00090006", seen, iface_data_o); else n_pass++;
        wait_idle(100, "timeout");
        bm_mode = 0;
    endtask

    task automatic test_reset_mid_transfer();
        bit seen;
        apply_reset();
        do_upd(4'b0111, 64'h0000_0C0C_0B0B_0A0A);
        wait_valid(20, seen);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (pending_o !== 4'h0) $display("FAIL mid_pending: got %h need 0", pending_o); else n_pass++;
        n_checks++; if ({iface_data_o, iface_valid_o, busy_o} !== 34'd0) $display("FAIL mid_outputs: got data=%08h v=%b b=%b need 0", iface_data_o, iface_valid_o, busy_o); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        dac_q.delete();
        repeat (30) @(posedge clk);
        n_checks++; if (dac_q.size() != 0) $display("FAIL mid_silent: got %0d words need 0", dac_q.size()); else n_pass++;
        do_upd(4'b0001, 64'h0000_0000_0000_0777);
        wait_idle(200, "mid_restart");
        n_checks++; if (dac_q[0] !== 32'h00080777) $display("FAIL mid_restart: got %08h need 00080777", dac_q[0]); else n_pass++;
    endtask

`ifdef GPA_FHDO_ADC_READBACK_EN
    task automatic test_adc_readback();
        apply_reset();
        adc_done_cnt = 0;
        do_upd(4'b0011, 64'h0000_0000_0008_0007);
        wait_idle(300, "adc");
        repeat (2) @(posedge clk);
        n_checks++; if (dac_q.size() != 2 || dac_q[1] !== 32'h00090008) $display("FAIL adc_dac: got %0d words last %08h need 2 / 00090008", dac_q.size(), dac_q[1]); else n_pass++;
        n_checks++; if (adc_q.size() != 1) $display("FAIL adc_count: got %0d need 1", adc_q.size()); else n_pass++;
        n_checks++; if (adc_q[0] !== 32'h40123456) $display("FAIL adc_word: got %08h need 40123456", adc_q[0]); else n_pass++;
        n_checks++; if (adc_done_cnt != 1) $display("FAIL adc_done: got %0d pulses need 1", adc_done_cnt); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_four_channels();
        test_rr_wrap();
        test_overwrite();
        test_issue_collision();
        test_overrun_saturate();
        test_timeout();
        test_reset_mid_transfer();
`ifdef GPA_FHDO_ADC_READBACK_EN
        test_adc_readback();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
